// File: rtl/serial_match_checker_pkg.sv
// Shared definitions for the serial match checker: FSM state encodings and
// default frame geometry.
package serial_match_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_FRAME_LEN = 16;
    localparam int DEF_CNT_W     = 5;
    localparam int DEF_THRESH    = 2;

endpackage

// File: rtl/serial_match_checker_exnor.sv
// Single-bit equality: c is 1 when a and b carry the same value.
module exnorGate (
    input  logic a,
    input  logic b,
    output logic c
);

    assign c = ~(a ^ b);

endmodule

// File: rtl/serial_match_checker.sv
// Frame-level match checker: counts matching / mismatching bit pairs over a
// fixed-length frame and produces a registered pass verdict plus done pulse.
module serial_match_checker
    import serial_match_checker_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int THRESH    = DEF_THRESH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] err_count
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] idx_q;
    logic             eq;
    logic             accept;
    logic             last_accept;
    logic             start_frame;
    logic [CNT_W:0]   err_final;

    exnorGate u_eq (
        .a (a_bit),
        .b (b_bit),
        .c (eq)
    );

    assign in_ready    = (state_q == ST_RUN);
    assign busy        = (state_q == ST_RUN);
    assign accept      = in_valid & in_ready;
    assign last_accept = accept && (idx_q == CNT_W'(FRAME_LEN - 1));
    assign start_frame = (state_q == ST_IDLE) && start;
    // Error total including the bit being accepted now, one bit wider so the
    // threshold compare cannot be fooled by a wrap.
    assign err_final   = {1'b0, err_count} + {{CNT_W{1'b0}}, ~eq};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; DONE lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)       state_d = ST_RUN;
            ST_RUN:  if (last_accept) state_d = ST_DONE;
            ST_DONE:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Bit index and match/error counters: cleared on frame start, stepped per accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            match_count <= '0;
            err_count   <= '0;
        end else if (start_frame) begin
            idx_q       <= '0;
            match_count <= '0;
            err_count   <= '0;
        end else if (accept) begin
            idx_q <= idx_q + 1'b1;
            if (eq) begin
                match_count <= match_count + 1'b1;
            end else begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    // Verdict and done pulse: captured on the edge that accepts the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            done <= last_accept;
            if (start_frame) begin
                pass <= 1'b0;
            end else if (last_accept) begin
                pass <= (err_final <= (CNT_W + 1)'(THRESH));
            end
        end
    end

endmodule

// File: tb/tb_serial_match_checker.sv
// Self-checking bench for serial_match_checker (FRAME_LEN=16, THRESH=2).
module tb_serial_match_checker;

    localparam int FL     = 16;
    localparam int CNT_W  = 5;
    localparam int THRESH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic             a_bit;
    logic             b_bit;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] match_count;
    logic [CNT_W-1:0] err_count;

    int total = 0;
    int bad   = 0;

    serial_match_checker #(.FRAME_LEN(FL), .CNT_W(CNT_W), .THRESH(THRESH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_bit       (a_bit),
        .b_bit       (b_bit),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .match_count (match_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        #2;
        total++;
        if ({in_ready, busy, done, pass, match_count, err_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b pass=%b m=%0d e=%0d, want all 0",
                     in_ready, busy, done, pass, match_count, err_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = i[0]; a_bit = 1'b1; b_bit = 1'b1;
            @(posedge clk); #1;
            total++;
            if ({in_ready, busy, done, match_count, err_count} !== '0) begin
                bad++;
                $display("FAIL idle_after_reset: got rdy=%b busy=%b done=%b m=%0d e=%0d, want all 0",
                         in_ready, busy, done, match_count, err_count);
            end
        end
        @(negedge clk); in_valid = 1'b0;
    endtask

    // One complete frame. n_mism<0 picks each pair's mismatch at random.
    task automatic run_frame(input int n_mism, input int gap_pct, input bit mid_start,
                             input bit valid_at_start, input string tag);
        bit a_q[FL];
        bit mis[FL];
        int placed, k, cyc, em, ee, tot_err;
        bit v, exp_pass;
        for (int i = 0; i < FL; i++) mis[i] = 1'b0;
        if (n_mism < 0) begin
            for (int i = 0; i < FL; i++) mis[i] = 1'($urandom_range(1));
        end else begin
            placed = 0;
            while (placed < n_mism) begin
                int p = $urandom_range(FL - 1);
                if (!mis[p]) begin mis[p] = 1'b1; placed++; end
            end
        end
        tot_err = 0;
        for (int i = 0; i < FL; i++) begin
            a_q[i] = 1'($urandom_range(1));
            tot_err += int'(mis[i]);
        end
        exp_pass = (tot_err <= THRESH);

        @(negedge clk);
        start = 1'b1; in_valid = valid_at_start; a_bit = 1'b1; b_bit = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({busy, in_ready, done, pass, match_count, err_count} !== {4'b1100, 10'd0}) begin
            bad++;
            $display("FAIL %s_start: got busy=%b rdy=%b done=%b pass=%b m=%0d e=%0d, want 1 1 0 0 0 0",
                     tag, busy, in_ready, done, pass, match_count, err_count);
        end

        k = 0; cyc = 0;
        while (k < FL && cyc < 400) begin
            @(negedge clk);
            start    = mid_start && ($urandom_range(3) == 0);
            v        = ($urandom_range(99) >= gap_pct);
            in_valid = v;
            a_bit    = v ? a_q[k] : 1'($urandom_range(1));
            b_bit    = v ? (a_q[k] ^ mis[k]) : 1'($urandom_range(1));
            @(posedge clk); #1;
            cyc++;
            if (v) k++;
            em = 0; ee = 0;
            for (int i = 0; i < k; i++) begin
                if (mis[i]) ee++; else em++;
            end
            total++;
            if (match_count !== CNT_W'(em) || err_count !== CNT_W'(ee)) begin
                bad++;
                $display("FAIL %s_counts: after %0d accepts got m=%0d e=%0d, want m=%0d e=%0d",
                         tag, k, match_count, err_count, em, ee);
            end
            total++;
            if (k < FL) begin
                if ({busy, done} !== 2'b10) begin
                    bad++;
                    $display("FAIL %s_run: got busy=%b done=%b, want 1 0", tag, busy, done);
                end
            end else begin
                if ({busy, in_ready, done, pass} !== {3'b001, exp_pass}) begin
                    bad++;
                    $display("FAIL %s_done: got busy=%b rdy=%b done=%b pass=%b, want 0 0 1 %b",
                             tag, busy, in_ready, done, pass, exp_pass);
                end
            end
        end
        if (k < FL) begin
            total++; bad++;
            $display("FAIL %s_timeout: accepted %0d of %0d", tag, k, FL);
        end

        // DONE cycle then an IDLE cycle: start/in_valid ignored, results held.
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            start = (j == 0); in_valid = 1'b1; a_bit = 1'b0; b_bit = 1'b1;
            @(posedge clk); #1;
            total++;
            if ({busy, in_ready, done, pass} !== {3'b000, exp_pass} ||
                match_count !== CNT_W'(FL - tot_err) || err_count !== CNT_W'(tot_err)) begin
                bad++;
                $display("FAIL %s_hold%0d: got busy=%b rdy=%b done=%b pass=%b m=%0d e=%0d, want 0 0 0 %b m=%0d e=%0d",
                         tag, j, busy, in_ready, done, pass, match_count, err_count,
                         exp_pass, FL - tot_err, tot_err);
            end
        end
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; a_bit = 1'($urandom_range(1)); b_bit = a_bit;
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++;
        if (match_count !== CNT_W'(7) || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre: got m=%0d busy=%b, want 7 1", match_count, busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, busy, done, pass, match_count, err_count} !== '0) begin
            bad++;
            $display("FAIL mid_reset: got rdy=%b busy=%b done=%b pass=%b m=%0d e=%0d, want all 0",
                     in_ready, busy, done, pass, match_count, err_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            total++;
            if ({busy, done, match_count} !== '0) begin
                bad++;
                $display("FAIL mid_after: got busy=%b done=%b m=%0d, want 0 0 0", busy, done, match_count);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        run_frame(0, 0, 1'b0, 1'b0, "all_match");
        run_frame(2, 0, 1'b0, 1'b0, "thresh2");
        run_frame(3, 0, 1'b0, 1'b0, "thresh3");
        run_frame(5, 50, 1'b1, 1'b0, "gapped");
        test_reset_mid();
        run_frame(1, 0, 1'b0, 1'b0, "after_reset");
        run_frame(4, 0, 1'b0, 1'b1, "valid_at_start");
        for (int r = 0; r < 6; r++) begin
            run_frame(-1, 30, 1'b1, r[0], "random");
        end
        run_frame(FL, 20, 1'b0, 1'b0, "all_err");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
